// File: rtl/sr_request_sequencer.sv
// sr_request_sequencer: turns bouncy async set/clear requests into clean, mutually exclusive
// one-cycle s/r pulses for a downstream SR flip-flop. Define SR_CLR_PRIORITY_EN for clear-first arbitration.
module sr_request_sequencer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int GAP_CYCLES      = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic set_req,
   input  logic clr_req,
   output logic s,
   output logic r,
   output logic q_model,
   output logic busy,
   output logic overrun
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES);
   localparam logic [GW-1:0] GAP_ONE  = GW'(1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PULSE_S = 2'd1;
   localparam logic [1:0] PULSE_R = 2'd2;
   localparam logic [1:0] GUARD   = 2'd3;

   // Bit 0 of every per-path vector is the set path, bit 1 the clear path.
   logic [1:0]    req;
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    deb;
   logic [1:0]    deb_d;
   logic [1:0]    ev;
   logic [CW-1:0] cnt [2];

   logic [1:0]    state;
   logic [1:0]    state_n;
   logic [GW-1:0] gap;
   logic [1:0]    pend;
   logic [1:0]    pend_n;
   logic [1:0]    cand;
   logic [1:0]    take;
   logic          is_idle;
   logic          expire;
   logic          ov_n;

   assign req = {clr_req, set_req};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1  <= '0;
         sync2  <= '0;
         deb    <= '0;
         deb_d  <= '0;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         sync1 <= req;
         sync2 <= sync1;
         deb_d <= deb;
         for (int unsigned i = 0; i < 2; i++) begin
            if (sync2[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DEB_LAST) begin
               deb[i] <= sync2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_ONE;
            end
         end
      end
   end

   assign ev = deb & ~deb_d;

   always_comb begin
      is_idle = (state == IDLE);
      expire  = (state == GUARD) && (gap == GAP_ONE);
      cand    = '0;
      if (is_idle) begin
         cand = pend | ev;
      end else if (expire) begin
         cand = pend;
      end
`ifdef SR_CLR_PRIORITY_EN
      take = cand[1] ? 2'b10 : cand;
`else
      take = cand[0] ? 2'b01 : cand;
`endif
      // In IDLE a fresh event is consumed directly; elsewhere it only fills its slot.
      pend_n = (pend & ~take) | (ev & ~(is_idle ? take : 2'b00));
      ov_n   = |(ev & pend & ~take);

      state_n = state;
      case (state)
         PULSE_S, PULSE_R: state_n = GUARD;
         GUARD:            if (expire) state_n = IDLE;
         default:          state_n = state;
      endcase
      if (take[0]) begin
         state_n = PULSE_S;
      end else if (take[1]) begin
         state_n = PULSE_R;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         pend    <= '0;
         gap     <= '0;
         s       <= 1'b0;
         r       <= 1'b0;
         q_model <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state   <= state_n;
         pend    <= pend_n;
         overrun <= ov_n;
         s       <= (state_n == PULSE_S);
         r       <= (state_n == PULSE_R);
         if (state_n == PULSE_S) begin
            q_model <= 1'b1;
         end else if (state_n == PULSE_R) begin
            q_model <= 1'b0;
         end
         if (state == PULSE_S || state == PULSE_R) begin
            gap <= GAP_LOAD;
         end else if (state == GUARD && !expire) begin
            gap <= gap - GAP_ONE;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/sr_request_sequencer.md
# sr_request_sequencer

Front-end stage for the SR flip-flop. It converts two asynchronous, possibly bouncy request lines (set and clear) into clean, single-cycle, mutually exclusive `s`/`r` pulses. The `s`/`r` outputs are never both high, so the flip-flop never receives the illegal 11 input. Each request path is synchronized, debounced and rising-edge detected. A small FSM then arbitrates the two paths, queues one pending event per type and enforces a guard gap between pulses. The block sits directly upstream of the flip-flop: its `s`/`r` drive the flip-flop's `s`/`r`, on the same clock.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronized level must differ from its debounced value before the debounced value flips. Minimum 1.
- `GAP_CYCLES`, default 2: number of guard cycles after every pulse. Minimum 1.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `set_req`  input  1  asynchronous set request; a level input, and only its rising edge is acted on.
- `clr_req`  input  1  asynchronous clear request; same rules as `set_req`.
- `s`  output  1  registered one-cycle set pulse to the flip-flop.
- `r`  output  1  registered one-cycle reset pulse to the flip-flop.
- `q_model`  output  1  expected flip-flop state: set to 1 with each `s` pulse, cleared to 0 with each `r` pulse.
- `busy`  output  1  high whenever the FSM is not in IDLE.
- `overrun`  output  1  one-cycle pulse when an event is dropped because its pending slot is already full.

## Operation
- **Synchronizer.** Each request passes through its own 2-flop synchronizer.
- **Debounce.** Each path has its own counter with width `$clog2(DEBOUNCE_CYCLES+1)`.
  - The counter increments each cycle the synchronized level differs from the debounced level (`deb`).
  - It clears to 0 on any cycle the two are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`, `deb` takes the synchronized value on that same edge and the counter clears.
- **Event.** An event is `deb & ~deb_d`, a rising edge of the debounced level, valid for one cycle. A falling `deb` produces no event.
- **FSM states: IDLE, PULSE_S, PULSE_R, GUARD.**
  - IDLE, on an event or pending flag → PULSE_S or PULSE_R, chosen by priority. The chosen item is consumed. A simultaneous event of the other type goes into its pending slot.
  - PULSE_S / PULSE_R drive `s=1` or `r=1` for exactly one cycle, then → GUARD. The gap counter loads `GAP_CYCLES`.
  - GUARD counts down. When it expires: if any pending flag is set → the PULSE state of the highest-priority pending flag, clearing that flag; otherwise → IDLE.
- **Events outside IDLE.** Events arriving in PULSE_* or GUARD set `pend_s` / `pend_r`.
  - An event whose flag is already set is dropped and pulses `overrun`.
  - Set and clear events arriving in the same cycle are both recorded.
- **Invariant.** `s & r` is never 1 in any cycle, including the cycles immediately after reset.
- **Reset.** `rst` asserted at any time, including mid-pulse, immediately gives:
  - `s=r=0`, `q_model=0`, `busy=0`, `overrun=0`;
  - FSM in IDLE, pending flags, counters, synchronizers and `deb` all 0.

## Timing
- Edges are numbered from 1, starting at the first edge that samples `set_req` high with the request held stable.
- Synchronizer output is 1 after edge 2.
- `deb` rises at edge 2+`DEBOUNCE_CYCLES`.
- `s` is high for the single cycle following edge 3+`DEBOUNCE_CYCLES`, i.e. edge 7 at the defaults. `clr_req` → `r` has identical latency.
- Minimum spacing between consecutive output pulses is 1+`GAP_CYCLES` cycles, i.e. rising edges of `s`/`r` are at least 3 cycles apart at the defaults.
- `q_model` updates on the same edge that raises `s` or `r`.
- `busy` rises on the same edge as the first pulse. It falls on the edge that returns the FSM to IDLE.
- Input glitches shorter than `DEBOUNCE_CYCLES` synchronized cycles produce no event.

## Configuration
- Macro: `SR_CLR_PRIORITY_EN`.
- Defined: clear wins. A simultaneous event pair, or both pending flags set, is serviced `r` first, then `s`.
- Undefined (default): set wins, so `s` first, then `r`.
- The macro affects only arbitration order. Latency, gap and overrun behaviour are unchanged.

## Test plan
- Defaults; `set_req` rises and is held. Expect a single `s` pulse in the cycle after edge 7, `q_model`=1, `r` stays 0 throughout.
- `clr_req` pulses high for 3 cycles with `DEBOUNCE_CYCLES`=4. Expect no `r` pulse and `busy` stays 0.
- `set_req` and `clr_req` rise on the same edge, macro undefined. Expect `s` pulse, then 2 guard cycles, then `r` pulse; final `q_model`=0. With `SR_CLR_PRIORITY_EN` defined, expect `r` then `s`; final `q_model`=1.
- Three clean `set_req` rising edges while the FSM is busy in GUARD. Expect one pending `s` serviced, one `overrun` pulse, and no more than 2 `s` pulses in total.
- `rst` asserted in the cycle where `s`=1. Expect `s`=0, `q_model`=0 and `busy`=0 asynchronously, with no pulse after release until a new request arrives.
- Random bouncy stimulus on both inputs for 10k cycles. Check that `s&r` is never 1, that pulse spacing is ≥ 1+`GAP_CYCLES`, and that `q_model` tracks a reference SR model.
